// File: rtl/decode_pkg.sv
// Shared decode definitions: format codes, opcode constants and small helpers
// used by the decode stage and its field extractor.
package decode_pkg;

  typedef enum logic [1:0] {
    FMT_A   = 2'd0,
    FMT_B   = 2'd1,
    FMT_C   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam logic [5:0] OPC_A_ZERO = 6'b000000;
  localparam logic [5:0] OPC_A_ONES = 6'b111111;
  localparam logic [5:0] OPC_B_LO   = 6'b100010;
  localparam logic [5:0] OPC_B_HI   = 6'b100011;
  localparam logic [5:0] OPC_C      = 6'b110000;

  function automatic fmt_e fmt_of(input logic [5:0] opc);
    fmt_e f;
    case (opc)
      OPC_A_ZERO, OPC_A_ONES: f = FMT_A;
      OPC_B_LO, OPC_B_HI:     f = FMT_B;
      OPC_C:                  f = FMT_C;
      default:                f = FMT_ILL;
    endcase
    return f;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    logic [15:0] r;
    if (en && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Purely combinational field extraction for one instruction word; the stage
// registers its results so the skid entry already holds decoded fields.
module decode_fields
  import decode_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int REG_AW   = 5,
  parameter int OPC_W    = 6,
  parameter int IMM_W    = 32,
  parameter int SIGN_EXT = 1,
  parameter int FUNC_W   = INSTR_W - 3*REG_AW - OPC_W
) (
  input  logic [INSTR_W-1:0] instr,
  output fmt_e               fmt,
  output logic [REG_AW-1:0]  rsrc1,
  output logic [REG_AW-1:0]  rsrc2,
  output logic [REG_AW-1:0]  rdst,
  output logic [OPC_W-1:0]   opcode,
  output logic [FUNC_W-1:0]  func,
  output logic [IMM_W-1:0]   imm,
  output logic               illegal
);

  localparam int BIMM_W = INSTR_W - 2*REG_AW - OPC_W;
  localparam int CIMM_W = INSTR_W - OPC_W;

  logic [BIMM_W-1:0] b_imm;
  logic [CIMM_W-1:0] c_imm;

  assign b_imm = instr[INSTR_W-2*REG_AW-1:OPC_W];
  assign c_imm = instr[INSTR_W-1:OPC_W];

  // Select fields by format; anything not used by a format stays zero.
  always_comb begin
    fmt     = fmt_of(6'(instr[OPC_W-1:0]));
    opcode  = instr[OPC_W-1:0];
    rsrc1   = '0;
    rsrc2   = '0;
    rdst    = '0;
    func    = '0;
    imm     = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_A: begin
        rsrc1 = instr[INSTR_W-1 -: REG_AW];
        rsrc2 = instr[INSTR_W-REG_AW-1 -: REG_AW];
        rdst  = instr[INSTR_W-2*REG_AW-1 -: REG_AW];
        func  = instr[INSTR_W-3*REG_AW-1:OPC_W];
      end
      FMT_B: begin
        rsrc1 = instr[INSTR_W-1 -: REG_AW];
        rsrc2 = instr[INSTR_W-REG_AW-1 -: REG_AW];
        if (SIGN_EXT != 0) begin
          imm = IMM_W'($signed(b_imm));
        end else begin
          imm = IMM_W'(b_imm);
        end
      end
      FMT_C: begin
        imm = IMM_W'(c_imm);
      end
      FMT_ILL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Single-cycle decode stage: input-side field extraction feeding an output
// register backed by a one-entry skid register, plus saturating statistics.
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int REG_AW   = 5,
  parameter int OPC_W    = 6,
  parameter int IMM_W    = 32,
  parameter int SIGN_EXT = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [INSTR_W-1:0]                  in_instr,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [1:0]                          out_fmt,
  output logic [REG_AW-1:0]                   out_rsrc1,
  output logic [REG_AW-1:0]                   out_rsrc2,
  output logic [REG_AW-1:0]                   out_rdst,
  output logic [OPC_W-1:0]                    out_opcode,
  output logic [INSTR_W-3*REG_AW-OPC_W-1:0]   out_func,
  output logic [IMM_W-1:0]                    out_imm,
  output logic                                out_illegal,
  output logic [15:0]                         cnt_decoded,
  output logic [15:0]                         cnt_illegal
);

  localparam int FUNC_W = INSTR_W - 3*REG_AW - OPC_W;
  localparam int DW     = 2 + 3*REG_AW + OPC_W + FUNC_W + IMM_W + 1;

  fmt_e              dec_fmt;
  logic [REG_AW-1:0] dec_rsrc1, dec_rsrc2, dec_rdst;
  logic [OPC_W-1:0]  dec_opcode;
  logic [FUNC_W-1:0] dec_func;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_illegal;
  logic [DW-1:0]     dec_word;

  logic [DW-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic          out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   cnt_dec_q, cnt_dec_d, cnt_ill_q, cnt_ill_d;
  logic          in_fire, out_fire;

  decode_fields #(
    .INSTR_W (INSTR_W),
    .REG_AW  (REG_AW),
    .OPC_W   (OPC_W),
    .IMM_W   (IMM_W),
    .SIGN_EXT(SIGN_EXT),
    .FUNC_W  (FUNC_W)
  ) u_fields (
    .instr  (in_instr),
    .fmt    (dec_fmt),
    .rsrc1  (dec_rsrc1),
    .rsrc2  (dec_rsrc2),
    .rdst   (dec_rdst),
    .opcode (dec_opcode),
    .func   (dec_func),
    .imm    (dec_imm),
    .illegal(dec_illegal)
  );

  // Illegal flag sits in bit 0 so the counter update can read it directly.
  assign dec_word = {dec_fmt, dec_rsrc1, dec_rsrc2, dec_rdst, dec_opcode,
                     dec_func, dec_imm, dec_illegal};
  assign {out_fmt, out_rsrc1, out_rsrc2, out_rdst, out_opcode,
          out_func, out_imm, out_illegal} = out_data_q;

  assign in_fire     = in_valid & in_ready_q;
  assign out_fire    = out_valid_q & out_ready;
  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign cnt_decoded = cnt_dec_q;
  assign cnt_illegal = cnt_ill_q;

  // Next-state for output/skid entries and counters; flush overrides everything.
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    cnt_dec_d    = cnt_dec_q;
    cnt_ill_d    = cnt_ill_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      cnt_dec_d = sat_inc(cnt_dec_q, out_fire);
      cnt_ill_d = sat_inc(cnt_ill_q, out_fire & out_data_q[0]);
      if (!out_valid_q || out_fire) begin
        if (skid_valid_q) begin
          out_data_d   = skid_data_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          out_data_d  = dec_word;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_data_d  = dec_word;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_dec_q    <= 16'd0;
      cnt_ill_q    <= 16'd0;
    end else begin
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_dec_q    <= cnt_dec_d;
      cnt_ill_q    <= cnt_ill_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode table, directed handshake/flush/reset
// sequences, random traffic against a queue-based model, counter saturation.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr;

  logic        in_ready, out_valid, out_illegal;
  logic [1:0]  out_fmt;
  logic [4:0]  out_rsrc1, out_rsrc2, out_rdst;
  logic [5:0]  out_opcode;
  logic [10:0] out_func;
  logic [31:0] out_imm;
  logic [15:0] cnt_decoded, cnt_illegal;

  logic        z_in_ready, z_out_valid, z_out_illegal;
  logic [1:0]  z_out_fmt;
  logic [4:0]  z_out_rsrc1, z_out_rsrc2, z_out_rdst;
  logic [5:0]  z_out_opcode;
  logic [10:0] z_out_func;
  logic [31:0] z_out_imm;
  logic [15:0] z_cnt_decoded, z_cnt_illegal;

  decode_stage #(.SIGN_EXT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_fmt(out_fmt), .out_rsrc1(out_rsrc1),
    .out_rsrc2(out_rsrc2), .out_rdst(out_rdst), .out_opcode(out_opcode),
    .out_func(out_func), .out_imm(out_imm), .out_illegal(out_illegal),
    .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
  );

  decode_stage #(.SIGN_EXT(0)) u_dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(z_out_valid),
    .out_ready(out_ready), .out_fmt(z_out_fmt), .out_rsrc1(z_out_rsrc1),
    .out_rsrc2(z_out_rsrc2), .out_rdst(z_out_rdst), .out_opcode(z_out_opcode),
    .out_func(z_out_func), .out_imm(z_out_imm), .out_illegal(z_out_illegal),
    .cnt_decoded(z_cnt_decoded), .cnt_illegal(z_cnt_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  opc;
    logic [10:0] func;
    logic [31:0] imm, imm_z;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: FIFO of accepted instruction words, capacity two.
  logic [31:0] mq[$];
  int          m_dec, m_ill;
  bit          m_ready;

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t    e;
    longint  u    = longint'(w);
    longint  opc  = u % 64;
    longint  bimm = (u / 64) % 65536;
    e = '0;
    e.opc = 6'(opc);
    if (opc == 0 || opc == 63) begin
      e.fmt  = 2'd0;
      e.rs1  = 5'(u / (1 << 27));
      e.rs2  = 5'((u / (1 << 22)) % 32);
      e.rd   = 5'((u / (1 << 17)) % 32);
      e.func = 11'((u / 64) % 2048);
    end else if (opc == 34 || opc == 35) begin
      e.fmt   = 2'd1;
      e.rs1   = 5'(u / (1 << 27));
      e.rs2   = 5'((u / (1 << 22)) % 32);
      e.imm_z = 32'(bimm);
      e.imm   = (bimm >= 32768) ? 32'(bimm - 65536) : 32'(bimm);
    end else if (opc == 48) begin
      e.fmt   = 2'd2;
      e.imm   = 32'(u / 64);
      e.imm_z = 32'(u / 64);
    end else begin
      e.fmt = 2'd3;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [1:0] fmt,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [5:0] opc,
                              input logic [10:0] func, input logic [31:0] imm,
                              input logic [31:0] imm_z, input logic ill);
    vec_t v;
    v.instr = instr;
    v.e = '{fmt: fmt, rs1: rs1, rs2: rs2, rd: rd, opc: opc, func: func,
            imm: imm, imm_z: imm_z, ill: ill};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dec   = 0;
    m_ill   = 0;
    m_ready = 1'b1;
  endtask

  task automatic model_step();
    exp_t e;
    bit   acc;
    if (flush) begin
      mq.delete();
      m_ready = 1'b1;
    end else begin
      acc = in_valid && m_ready;
      if (mq.size() > 0 && out_ready) begin
        e = ref_decode(mq[0]);
        if (m_dec < 65535) m_dec++;
        if (e.ill && m_ill < 65535) m_ill++;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(in_instr);
      m_ready = (mq.size() < 2);
    end
  endtask

  task automatic check_all();
    exp_t e;
    chk("in_ready", in_ready, m_ready);
    chk("out_valid", out_valid, (mq.size() > 0));
    chk("cnt_decoded", cnt_decoded, m_dec);
    chk("cnt_illegal", cnt_illegal, m_ill);
    if (mq.size() > 0) begin
      e = ref_decode(mq[0]);
      chk("fmt", out_fmt, e.fmt);
      chk("rsrc1", out_rsrc1, e.rs1);
      chk("rsrc2", out_rsrc2, e.rs2);
      chk("rdst", out_rdst, e.rd);
      chk("opcode", out_opcode, e.opc);
      chk("func", out_func, e.func);
      chk("imm", out_imm, e.imm);
      chk("illegal", out_illegal, e.ill);
      chk("imm_zext", z_out_imm, e.imm_z);
    end
  endtask

  // Called at a falling edge; drives, clocks once, checks at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] w, input bit ordy,
                       input bit fl, output bit acc);
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    acc = v && m_ready && !fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  vec_t        tbl[7];
  bit          acc;
  logic [15:0] sv_dec, sv_ill;
  logic [31:0] w;
  int          r;

  initial begin
    tbl[0] = mk((32'd3 << 27) | (32'd4 << 22) | (32'h8001 << 6) | 32'h22,
                2'd1, 5'd3, 5'd4, 5'd0, 6'h22, 11'h0, 32'hFFFF8001, 32'h00008001, 1'b1 ^ 1'b1);
    tbl[1] = mk(32'hFFFFFFD5, 2'd3, 5'd0, 5'd0, 5'd0, 6'h15, 11'h0, 32'h0, 32'h0, 1'b1);
    tbl[2] = mk((32'd31 << 27) | (32'd1 << 22) | (32'd17 << 17) | (32'h5A5 << 6),
                2'd0, 5'd31, 5'd1, 5'd17, 6'h00, 11'h5A5, 32'h0, 32'h0, 1'b0);
    tbl[3] = mk((32'd31 << 22) | (32'h7FF << 6) | 32'h3F,
                2'd0, 5'd0, 5'd31, 5'd0, 6'h3F, 11'h7FF, 32'h0, 32'h0, 1'b0);
    tbl[4] = mk((32'd1 << 27) | (32'd2 << 22) | (32'h7FFF << 6) | 32'h23,
                2'd1, 5'd1, 5'd2, 5'd0, 6'h23, 11'h0, 32'h00007FFF, 32'h00007FFF, 1'b0);
    tbl[5] = mk(32'hFFFFFFF0, 2'd2, 5'd0, 5'd0, 5'd0, 6'h30, 11'h0, 32'h03FFFFFF, 32'h03FFFFFF, 1'b0);
    tbl[6] = mk(32'h12345660, 2'd3, 5'd0, 5'd0, 5'd0, 6'h20, 11'h0, 32'h0, 32'h0, 1'b1);

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fields", {out_fmt, out_rsrc1, out_rsrc2, out_rdst, out_opcode, out_func, out_illegal}, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_counters", {cnt_decoded, cnt_illegal}, 0);
    rst = 1'b0;

    // Decode table, one instruction per cycle with out_ready high.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, tbl[i].instr, 1'b1, 1'b0, acc);
      chk("tbl_accept", acc, 1);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_fmt", out_fmt, tbl[i].e.fmt);
      chk("tbl_rsrc1", out_rsrc1, tbl[i].e.rs1);
      chk("tbl_rsrc2", out_rsrc2, tbl[i].e.rs2);
      chk("tbl_rdst", out_rdst, tbl[i].e.rd);
      chk("tbl_opcode", out_opcode, tbl[i].e.opc);
      chk("tbl_func", out_func, tbl[i].e.func);
      chk("tbl_imm", out_imm, tbl[i].e.imm);
      chk("tbl_imm_zext", z_out_imm, tbl[i].e.imm_z);
      chk("tbl_illegal", out_illegal, tbl[i].e.ill);
    end
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("tbl_cnt_decoded", cnt_decoded, 7);
    chk("tbl_cnt_illegal", cnt_illegal, 2);

    // Stall: three back-to-back instructions, out_ready low for two cycles.
    cycle(1'b1, 32'h0800_0000, 1'b0, 1'b0, acc);
    chk("stall_acc1", acc, 1);
    cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0, acc);
    chk("stall_acc2", acc, 1);
    chk("stall_in_ready_low", in_ready, 0);
    cycle(1'b1, 32'h1800_0000, 1'b1, 1'b0, acc);
    chk("stall_acc3_blocked", acc, 0);
    chk("stall_skid_moved", out_rsrc1, 2);
    chk("stall_in_ready_high", in_ready, 1);
    cycle(1'b1, 32'h1800_0000, 1'b1, 1'b0, acc);
    chk("stall_acc3", acc, 1);
    chk("stall_third", out_rsrc1, 3);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Flush with both entries full and a new instruction offered.
    cycle(1'b1, 32'h2000_0022, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h2800_0015, 1'b0, 1'b0, acc);
    sv_dec = cnt_decoded; sv_ill = cnt_illegal;
    cycle(1'b1, 32'h3000_0000, 1'b1, 1'b1, acc);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_cnt_dec", cnt_decoded, sv_dec);
    chk("flush_cnt_ill", cnt_illegal, sv_ill);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("flush_still_empty", out_valid, 0);

    // Asynchronous reset in the middle of a stalled transfer.
    cycle(1'b1, 32'h0840_0000, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h0880_0000, 1'b0, 1'b0, acc);
    in_valid = 1'b1; in_instr = 32'h08C0_0000;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_fields", {out_fmt, out_rsrc1, out_rsrc2, out_rdst, out_opcode, out_func, out_illegal}, 0);
    chk("arst_counters", {cnt_decoded, cnt_illegal}, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h0900_0000, 1'b0, 1'b0, acc);
    chk("arst_first_accept", out_rsrc1, 1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      w = $urandom;
      r = $urandom_range(0, 5);
      case (r)
        0: w[5:0] = 6'h00;
        1: w[5:0] = 6'h3F;
        2: w[5:0] = 6'h22;
        3: w[5:0] = 6'h23;
        4: w[5:0] = 6'h30;
        default: w[5:0] = w[5:0];
      endcase
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
            $urandom_range(0, 39) == 0, acc);
    end

    // Counter saturation with continuous legal traffic.
    for (int i = 0; i < 65545; i++) begin
      cycle(1'b1, {$urandom} & 32'hFFFF_FFC0, 1'b1, 1'b0, acc);
    end
    chk("sat_cnt_decoded", cnt_decoded, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter INSTR_W, default 32, instruction word width.
REQ-002 Parameter REG_AW, default 5, register address width.
REQ-003 Parameter OPC_W, default 6, opcode width, in instruction bits [OPC_W-1:0] for every format.
REQ-004 Parameter IMM_W, default 32, width of the extended immediate output.
REQ-005 Parameter SIGN_EXT, default 1; 1 means format-(b) immediate is sign-extended, 0 means zero-extended.
REQ-006 Port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Ports in_valid (input, 1), in_ready (output, 1), in_instr (input, INSTR_W): instruction handshake.
REQ-009 Port flush, input, 1, discards all buffered instructions.
REQ-010 Ports out_valid (output, 1) and out_ready (input, 1): decoded-result handshake.
REQ-011 Outputs out_fmt (2), out_rsrc1/out_rsrc2/out_rdst (REG_AW each), out_opcode (OPC_W), out_func (INSTR_W-3*REG_AW-OPC_W), out_imm (IMM_W) and out_illegal (1).
REQ-012 Outputs cnt_decoded and cnt_illegal, 16 bits each: saturating statistics counters.

Function
REQ-013 The block SHALL decode the format from the opcode: 000000 or 111111 gives fmt 0 (a); 100010 or 100011 gives fmt 1 (b); 110000 gives fmt 2 (c); any other opcode gives fmt 3 (illegal).
REQ-014 Fmt 0 SHALL decode as follows: rsrc1 = top REG_AW bits, rsrc2 = next REG_AW bits, rdst = next REG_AW bits, func = the bits between rdst and opcode, and imm = 0.
REQ-015 Fmt 1 SHALL decode as follows: rsrc1 and rsrc2 as in fmt 0, rdst = 0, func = 0, and imm = bits [INSTR_W-2*REG_AW-1:OPC_W] extended to IMM_W per SIGN_EXT.
REQ-016 Fmt 2 SHALL decode as follows: rsrc1, rsrc2 and rdst = 0, func = 0, and imm = bits [INSTR_W-1:OPC_W] zero-extended.
REQ-017 Fmt 3 SHALL set out_illegal = 1, pass the opcode through, and zero every other field.
REQ-018 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-019 Latency SHALL be one cycle: an instruction accepted into an empty stage SHALL be presented on the outputs the next cycle.
REQ-020 Storage SHALL be an output register plus a one-entry skid register; in_ready SHALL equal the registered inverse of skid occupancy.
REQ-021 If an instruction is accepted while the output register holds data and out_ready is low, that instruction SHALL go to the skid register and in_ready SHALL fall the next cycle.
REQ-022 When the output transfers and the skid register is occupied, the skid contents SHALL move to the output register in the same edge and in_ready SHALL rise.
REQ-023 With out_ready held high, the stage SHALL sustain one instruction per cycle with no bubbles.
REQ-024 Outputs SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 Flush SHALL take priority over all other events: it clears both entries, any instruction offered in the flush cycle is dropped, and the next cycle has out_valid = 0 and in_ready = 1.
REQ-026 cnt_decoded SHALL increment on each output transfer; cnt_illegal SHALL increment on each output transfer with out_illegal = 1.
REQ-027 Both counters SHALL saturate at 0xFFFF, and flushed entries SHALL NOT be counted.

Reset
REQ-028 Reset SHALL asynchronously force out_valid = 0, the skid register empty, in_ready = 1, all decoded fields = 0, out_fmt = 0, out_illegal = 0 and both counters = 0.
REQ-029 On reset assertion mid-transfer, any in-flight instructions SHALL be lost; the first acceptance after release SHALL be on the first clk edge with rst low.

Structure
REQ-030 Format encodings (FMT_A=0, FMT_B=1, FMT_C=2, FMT_ILL=3) and the opcode constants SHALL live in the shared package decode_pkg.
REQ-031 The combinational field extraction SHALL be a sub-module named decode_fields, instantiated once at the input so the skid register holds decoded results.

Verification
REQ-032 Scenario: fmt 1, rsrc1=3, rsrc2=4, imm16=0x8001, opcode 100010, SIGN_EXT=1 -> one cycle later out_fmt=1, out_rsrc1=3, out_rsrc2=4, out_rdst=0, out_imm=0xFFFF8001.
REQ-033 Scenario: the same instruction with SIGN_EXT=0 -> out_imm=0x00008001.
REQ-034 Scenario: opcode 010101 -> out_fmt=3, out_illegal=1, other fields 0, cnt_illegal incremented by 1 on the output transfer.
REQ-035 Scenario: three back-to-back instructions with out_ready low for 2 cycles -> in_ready drops after the second acceptance, no instruction lost or reordered, order preserved at output.
REQ-036 Scenario: flush asserted with both entries full and in_valid high -> next cycle out_valid=0, in_ready=1, counters unchanged.
REQ-037 Scenario: 65540 legal output transfers -> cnt_decoded=0xFFFF.
